// File: rtl/xgmii_tx_arbiter.sv
// Round-robin frame arbiter for one 64-bit XGMII TX port.
// One grant per frame, programmable idle gap, link gating and grant watchdog.
module xgmii_tx_arbiter #(
  parameter int NREQ     = 4,
  parameter int IFG_W    = 8,
  parameter int CNT_W    = 32,
  parameter int WDOG_MAX = 1024
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  enable,
  input  logic                  link_up,
  input  logic [IFG_W-1:0]      ifg_cycles,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       frame_done,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic                  wdog_tmo,
  output logic [NREQ*CNT_W-1:0] grant_cnt
);

  localparam int PW     = $clog2(NREQ);
  localparam int WDOG_W = $clog2(WDOG_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [PW-1:0]     ptr;
  logic [PW-1:0]     ptr_nxt;
  logic [PW-1:0]     sel;
  logic [NREQ-1:0]   sel_oh;
  logic              found;
  logic              start;
  logic              fin;
  logic              expire;
  logic [IFG_W-1:0]  gap_cnt;
  logic [WDOG_W-1:0] wdog;

  // Rotating priority search starting at ptr.
  always_comb begin
    found   = 1'b0;
    sel     = '0;
    ptr_nxt = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        found   = 1'b1;
        sel     = PW'((int'(ptr) + k) % NREQ);
        ptr_nxt = PW'((int'(ptr) + k + 1) % NREQ);
      end
    end
  end

  assign sel_oh = NREQ'(1) << sel;
  assign start  = enable & link_up & found;
  // A dropped request of the granted source is an abort and ends the frame.
  assign fin    = (|(frame_done & grant)) | ~(|(req & grant));
  assign expire = (wdog == WDOG_W'(WDOG_MAX - 1));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = GRANT;
      end
      GRANT: begin
        if (fin || expire)
          state_nxt = (ifg_cycles == '0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_cnt <= IFG_W'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      grant     <= '0;
      ptr       <= '0;
      gap_cnt   <= '0;
      wdog      <= '0;
      wdog_tmo  <= 1'b0;
      grant_cnt <= '0;
    end else begin
      wdog_tmo <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            grant <= sel_oh;
            ptr   <= ptr_nxt;
            wdog  <= '0;
            grant_cnt[sel*CNT_W +: CNT_W] <=
              grant_cnt[sel*CNT_W +: CNT_W] + CNT_W'(1);
          end
        end
        GRANT: begin
          if (fin || expire) begin
            grant    <= '0;
            gap_cnt  <= ifg_cycles;
            // A real frame end on the expiry cycle is not a timeout.
            wdog_tmo <= ~fin;
          end else begin
            wdog <= wdog + WDOG_W'(1);
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - IFG_W'(1);
        end
        default: grant <= '0;
      endcase
    end
  end

endmodule
